// File: rtl/multichannel_shift_register.sv
// Multi-channel tapped shift register: CHANNELS lanes of SIZE taps shifting in lockstep.
// Optional synchronous clear port is enabled by defining SR_CLEAR_EN.
module multichannel_shift_register #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 1,
  localparam int CW        = $clog2(SIZE + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 shift_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       shift_in,
`ifdef SR_CLEAR_EN
  input  logic                                 clear,
`endif
  output logic [CHANNELS*DATA_WIDTH-1:0]       shift_out,
  output logic                                 out_valid,
  output logic [CHANNELS*SIZE*DATA_WIDTH-1:0]  data_out,
  output logic [CW-1:0]                        fill_count,
  output logic                                 full
);

  localparam logic [CW-1:0] FULL_CNT = CW'(SIZE);

  logic [CHANNELS*SIZE*DATA_WIDTH-1:0] taps;

  assign data_out = taps;
  assign full     = (fill_count == FULL_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      taps       <= '0;
      shift_out  <= '0;
      out_valid  <= 1'b0;
      fill_count <= '0;
    end
`ifdef SR_CLEAR_EN
    // clear wins over shift_en: the incoming sample is dropped
    else if (clear) begin
      taps       <= '0;
      shift_out  <= '0;
      out_valid  <= 1'b0;
      fill_count <= '0;
    end
`endif
    else begin
      out_valid <= 1'b0;
      if (shift_en) begin
        out_valid <= full;
        if (!full) fill_count <= fill_count + 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          shift_out[c*DATA_WIDTH +: DATA_WIDTH] <= taps[(c*SIZE + SIZE - 1)*DATA_WIDTH +: DATA_WIDTH];
          taps[(c*SIZE)*DATA_WIDTH +: DATA_WIDTH] <= shift_in[c*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < SIZE; i++) begin
            taps[(c*SIZE + i)*DATA_WIDTH +: DATA_WIDTH] <= taps[(c*SIZE + i - 1)*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

endmodule
